// File: rtl/score_keeper.sv
// ============================================================================
//  Module      : score_keeper
//  Description : Game-state bookkeeping for the HUD. Turns hit pulses into a
//                saturating score, tracks lives, the death/respawn/game-over
//                sequence and the high score. Outputs update per frame.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module score_keeper #(
    parameter int START_LIVES   = 3,
    parameter int DEATH_FRAMES  = 60,
    parameter int EXTRA_LIFE_AT = 1500,
    parameter int UFO_POINTS    = 100,
    parameter int MAX_SCORE     = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        new_game,
    input  logic        alien_hit,
    input  logic [1:0]  alien_type,
    input  logic        ufo_hit,
    input  logic        player_hit,
    output logic [13:0] score,
    output logic [1:0]  lives,
    output logic [13:0] hi_score,
    output logic        dying,
    output logic        game_over
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_DYING     = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam logic [13:0] c_max_score   = 14'(MAX_SCORE);
    localparam logic [14:0] c_extra_at    = 15'(EXTRA_LIFE_AT);
    localparam logic [14:0] c_ufo_points  = 15'(UFO_POINTS);
    localparam logic [1:0]  c_start_lives = 2'(START_LIVES);
    localparam logic [7:0]  c_death_len   = 8'(DEATH_FRAMES);
    localparam logic [1:0]  c_max_lives   = 2'd3;

    state_t      r_state;
    logic [13:0] r_score;
    logic [1:0]  r_lives;
    logic [13:0] r_score_out;
    logic [1:0]  r_lives_out;
    logic [13:0] r_hi_score;
    logic        r_dying;
    logic        r_game_over;
    logic        r_extra_given;
    logic [7:0]  r_death_cnt;

    state_t      w_state_nxt;
    logic [13:0] w_score_nxt;
    logic [1:0]  w_lives_nxt;
    logic        w_extra_nxt;
    logic [7:0]  w_death_cnt_nxt;
    logic [14:0] w_points;
    logic [14:0] w_sum;
    logic [13:0] w_score_sat;
    logic        w_award;
    logic        w_hit_accept;

    // Points for this cycle, summed one bit wider than the score so the
    // saturation compare sees any overflow past MAX_SCORE.
    always_comb begin
        w_points = 15'd0;
        if (alien_hit) begin
            case (alien_type)
                2'd0:    w_points = 15'd10;
                2'd1:    w_points = 15'd20;
                2'd2:    w_points = 15'd30;
                default: w_points = 15'd0;
            endcase
        end
        if (ufo_hit) begin
            w_points = w_points + c_ufo_points;
        end
        w_sum       = {1'b0, r_score} + w_points;
        w_score_sat = (w_sum > {1'b0, c_max_score}) ? c_max_score : w_sum[13:0];
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_score_nxt     = r_score;
        w_lives_nxt     = r_lives;
        w_extra_nxt     = r_extra_given;
        w_death_cnt_nxt = r_death_cnt;
        w_award         = 1'b0;
        w_hit_accept    = 1'b0;

        if (new_game) begin
            w_state_nxt = ST_PLAYING;
            w_score_nxt = 14'd0;
            w_lives_nxt = c_start_lives;
            w_extra_nxt = 1'b0;
        end else begin
            if (r_state == ST_PLAYING || r_state == ST_DYING) begin
                w_score_nxt = w_score_sat;
                if (!r_extra_given && ({1'b0, w_score_sat} >= c_extra_at)) begin
                    w_award     = 1'b1;
                    w_extra_nxt = 1'b1;
                end
            end

            w_hit_accept = (r_state == ST_PLAYING) && player_hit;

            // A hit and an award in the same cycle cancel out.
            if (w_hit_accept && !w_award) begin
                w_lives_nxt = r_lives - 2'd1;
            end else if (!w_hit_accept && w_award && (r_lives != c_max_lives)) begin
                w_lives_nxt = r_lives + 2'd1;
            end

            case (r_state)
                ST_PLAYING: begin
                    if (w_hit_accept) begin
                        w_state_nxt     = ST_DYING;
                        w_death_cnt_nxt = c_death_len;
                    end
                end
                ST_DYING: begin
                    if (frame_tick) begin
                        if (r_death_cnt <= 8'd1) begin
                            w_death_cnt_nxt = 8'd0;
                            w_state_nxt     = (w_lives_nxt == 2'd0) ? ST_GAME_OVER : ST_PLAYING;
                        end else begin
                            w_death_cnt_nxt = r_death_cnt - 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_score       <= 14'd0;
            r_lives       <= c_start_lives;
            r_score_out   <= 14'd0;
            r_lives_out   <= c_start_lives;
            r_hi_score    <= 14'd0;
            r_dying       <= 1'b0;
            r_game_over   <= 1'b0;
            r_extra_given <= 1'b0;
            r_death_cnt   <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_score       <= w_score_nxt;
            r_lives       <= w_lives_nxt;
            r_extra_given <= w_extra_nxt;
            r_death_cnt   <= w_death_cnt_nxt;
            r_dying       <= (w_state_nxt == ST_DYING);
            r_game_over   <= (w_state_nxt == ST_GAME_OVER);

            // HUD copies move only at frame boundaries, or at once on a new game.
            if (new_game || frame_tick) begin
                r_score_out <= w_score_nxt;
                r_lives_out <= w_lives_nxt;
            end

            if ((r_state == ST_DYING) && (w_state_nxt == ST_GAME_OVER) &&
                (w_score_nxt > r_hi_score)) begin
                r_hi_score <= w_score_nxt;
            end
        end
    end

    assign score     = r_score_out;
    assign lives     = r_lives_out;
    assign hi_score  = r_hi_score;
    assign dying     = r_dying;
    assign game_over = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
//  Module      : tb_score_keeper
//  Description : Directed self-checking bench for score_keeper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_score_keeper;

    logic        clk;
    logic        rst_n;
    logic        frame_tick;
    logic        new_game;
    logic        alien_hit;
    logic [1:0]  alien_type;
    logic        ufo_hit;
    logic        player_hit;
    logic [13:0] score;
    logic [1:0]  lives;
    logic [13:0] hi_score;
    logic        dying;
    logic        game_over;

    int n_cmp = 0;
    int n_err = 0;

    score_keeper dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .new_game   (new_game),
        .alien_hit  (alien_hit),
        .alien_type (alien_type),
        .ufo_hit    (ufo_hit),
        .player_hit (player_hit),
        .score      (score),
        .lives      (lives),
        .hi_score   (hi_score),
        .dying      (dying),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
        end
    endtask

    task automatic aliens(input logic [1:0] t, input int n);
        for (int i = 0; i < n; i++) begin
            alien_hit  = 1'b1;
            alien_type = t;
            tick();
            alien_hit  = 1'b0;
        end
    endtask

    task automatic ufos(input int n);
        for (int i = 0; i < n; i++) begin
            ufo_hit = 1'b1;
            tick();
            ufo_hit = 1'b0;
        end
    endtask

    task automatic start_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    task automatic kill();
        player_hit = 1'b1;
        tick();
        player_hit = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; new_game = 1'b0; alien_hit = 1'b0;
        alien_type = 2'd0; ufo_hit = 1'b0; player_hit = 1'b0;
        tick(); tick();
        check("rst_score", score, 0);
        check("rst_lives", lives, 3);
        check("rst_hi", hi_score, 0);
        check("rst_dying", dying, 0);
        check("rst_gameover", game_over, 0);
        rst_n = 1'b1;

        // Idle ignores events
        aliens(2'd2, 2); ufos(1); frames(1);
        check("idle_score", score, 0);

        // Basic scoring, held until frame tick
        start_game();
        aliens(2'd2, 3);
        check("no_tick_score", score, 0);
        frames(1);
        check("tick_score", score, 90);
        check("tick_lives", lives, 3);

        // Extra life at 1500 while already at 3 lives
        ufos(14); aliens(2'd0, 1); frames(1);
        check("extra_score", score, 1500);
        check("extra_sat_lives", lives, 3);

        // Saturation at 9999
        ufos(84); aliens(2'd2, 3); frames(1);
        check("pre_sat_score", score, 9990);
        alien_hit = 1'b1; alien_type = 2'd2; ufo_hit = 1'b1;
        tick();
        alien_hit = 1'b0; ufo_hit = 1'b0;
        frames(1);
        check("sat_score", score, 9999);
        check("sat_lives", lives, 3);

        // Death sequence; second hit during DYING ignored
        kill();
        check("dying_set", dying, 1);
        kill();
        frames(59);
        check("dying_59", dying, 1);
        check("lives_2", lives, 2);
        frames(1);
        check("respawn", dying, 0);
        kill(); frames(60);
        check("lives_1", lives, 1);
        kill(); frames(59);
        check("go_not_yet", game_over, 0);
        check("lives_0", lives, 0);
        frames(1);
        check("game_over", game_over, 1);
        check("hi_loaded", hi_score, 9999);
        ufos(1); frames(1);
        check("go_score_hold", score, 9999);

        // New game: immediate outputs, hi_score kept; extra life from 2 lives
        start_game();
        check("ng_score", score, 0);
        check("ng_lives", lives, 3);
        check("ng_hi", hi_score, 9999);
        check("ng_gameover", game_over, 0);
        kill(); frames(60);
        check("l2_before_extra", lives, 2);
        ufos(15); frames(1);
        check("extra_from_2", lives, 3);
        kill(); frames(60); ufos(10); frames(1);
        check("no_second_extra", lives, 2);
        check("no_second_score", score, 2500);

        // Player hit coincident with extra-life crossing
        start_game();
        kill(); frames(60);
        ufos(14);
        ufo_hit = 1'b1; player_hit = 1'b1;
        tick();
        ufo_hit = 1'b0; player_hit = 1'b0;
        check("coinc_dying", dying, 1);
        aliens(2'd1, 1);
        frames(1);
        check("coinc_lives", lives, 2);
        check("coinc_score", score, 1520);
        frames(59);
        check("coinc_respawn", dying, 0);

        // New game during DYING at counter 30
        kill(); frames(30);
        check("mid_dying", dying, 1);
        start_game();
        check("ng_dying_score", score, 0);
        check("ng_dying_lives", lives, 3);
        check("ng_dying_flag", dying, 0);

        // Reset mid-game
        aliens(2'd2, 1); frames(1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst2_hi", hi_score, 0);
        check("rst2_score", score, 0);
        aliens(2'd2, 2); kill(); frames(1);
        check("rst2_idle_score", score, 0);
        check("rst2_idle_dying", dying, 0);
        check("rst2_idle_lives", lives, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
